uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int N_REQ_DEF  = 4;
  localparam int D_BITS_DEF = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo N_REQ.
module uart_rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Define UART_TX_ARB_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int D_BITS = D_BITS_DEF,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*D_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [D_BITS-1:0]       tx_din,
  output logic                    tx_start,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id
);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic              last_q;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              handshake;
  logic              ptr_advance;
  logic [IDX_W-1:0]  next_ptr;
  logic [D_BITS-1:0] win_data;

`ifdef UART_TX_ARB_LOCK_EN
  // last_q low means the previous byte was mid-message: only that requester may continue.
  assign eligible    = last_q ? req_valid : (req_valid & (N_REQ'(1) << grant_id));
  assign ptr_advance = last_q;
`else
  logic unused_last_q;
  assign unused_last_q = last_q;
  assign eligible      = req_valid;
  assign ptr_advance   = 1'b1;
`endif

  uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (eligible),
    .rr_ptr (rr_ptr),
    .grant  (win_onehot),
    .idx    (win_idx),
    .found  (win_found)
  );

  assign handshake = (state == IDLE) && win_found;
  assign req_ready = handshake ? win_onehot : '0;
  assign win_data  = req_data[int'(win_idx)*D_BITS +: D_BITS];
  assign next_ptr  = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_din   <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      last_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            state    <= START;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            tx_din   <= win_data;
            grant_id <= win_idx;
            last_q   <= req_last[win_idx];
            if (ptr_advance) rr_ptr <= next_ptr;
          end
        end
        START: begin
          state    <= WAIT;
          tx_start <= 1'b0;
        end
        WAIT: begin
          if (tx_done_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*D-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [D-1:0]   tx_din;
  logic           tx_start;
  logic           tx_done_tick = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .D_BITS(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_din       (tx_din),
    .tx_start     (tx_start),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model, checked on every falling edge ----------------
  bit         m_on = 1'b0;
  bit         m_busy, m_start, m_lock;
  int         m_ptr, m_gid;
  logic [7:0] m_din;
  logic [N-1:0] m_acc = '0;

  always @(negedge clk) begin
    logic [N-1:0] elig;
    logic [N-1:0] exp_ready;
    int win;
    if (reset) begin
      m_on = 1'b1; m_busy = 0; m_start = 0; m_lock = 0;
      m_ptr = 0; m_gid = 0; m_din = '0; m_acc = '0;
    end else if (m_on) begin
      elig = m_lock ? (req_valid & (N'(1) << m_gid)) : req_valid;
      win = -1;
      if (!m_busy)
        for (int k = 0; k < N; k++)
          if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      exp_ready = (win >= 0) ? (N'(1) << win) : '0;
      check("m_req_ready", req_ready, exp_ready);
      check("m_tx_start", tx_start, m_start);
      check("m_busy", busy, m_busy);
      check("m_tx_din", tx_din, m_din);
      check("m_grant_id", grant_id, 32'(m_gid));
      m_acc = exp_ready;
      if (win >= 0) begin
        m_busy = 1; m_start = 1;
        m_din = req_data[win*D +: D];
        if (!m_lock) m_ptr = (win + 1) % N;
        m_gid = win;
`ifdef UART_TX_ARB_LOCK_EN
        m_lock = !req_last[win];
`endif
      end else if (m_start) begin
        m_start = 0;
      end else if (m_busy && tx_done_tick) begin
        m_busy = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i, input logic [7:0] d, input bit l);
    req_valid[i] = 1'b1;
    req_data[i*D +: D] = d;
    req_last[i] = l;
  endtask

  // One full byte: handshake in IDLE, START, one WAIT cycle ended by tx_done_tick.
  // The winner then presents (nv, nd, nl) as its next offer.
  task automatic xfer(input int idx, input logic [7:0] d, input bit nv,
                      input logic [7:0] nd, input bit nl);
    #1;
    check("hs_ready", req_ready, 32'(1) << idx);
    step();
    check("start_pulse", tx_start, 1);
    check("start_grant", grant_id, idx);
    check("start_din", tx_din, d);
    check("start_busy", busy, 1);
    check("start_ready", req_ready, 0);
    req_valid[idx] = nv; req_data[idx*D +: D] = nd; req_last[idx] = nl;
    step();
    check("wait_start", tx_start, 0);
    check("wait_busy", busy, 1);
    check("wait_din", tx_din, d);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_start", tx_start, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, tx_start, 0);
    check({tag, "_din"}, tx_din, 0);
    check({tag, "_grant"}, grant_id, 0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    #1;
    check_reset_values("rst");

    // Stray done tick with no requests
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    step();
    check_reset_values("stray_done");

    // Single request
    offer(0, 8'h55, 1'b1);
    xfer(0, 8'h55, 0, 8'h00, 0);

    // Fairness from a fresh pointer: 0,1,2,3,0
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < N; i++) offer(i, 8'h10 + 8'(i), 1'b1);
    for (int i = 0; i < N; i++) xfer(i, 8'h10 + 8'(i), 1, 8'h20 + 8'(i), 1);
    xfer(0, 8'h20, 0, 8'h00, 0);

    // Wrap: grant 3, then with 3 and 1 valid requester 1 wins
    req_valid = 4'b1000;
    xfer(3, 8'h23, 1, 8'h33, 1);
    req_valid[1] = 1'b1;
    xfer(1, 8'h21, 0, 8'h00, 0);
    req_valid[3] = 1'b0;

    // Multi-byte message from requester 2 while requester 0 waits
    offer(2, 8'hA1, 1'b0);
    offer(0, 8'h77, 1'b1);
    xfer(2, 8'hA1, 1, 8'hA2, 1);
`ifdef UART_TX_ARB_LOCK_EN
    xfer(2, 8'hA2, 0, 8'h00, 0);
    xfer(0, 8'h77, 0, 8'h00, 0);
`else
    xfer(0, 8'h77, 0, 8'h00, 0);
    xfer(2, 8'hA2, 0, 8'h00, 0);
`endif

    // Reset in WAIT, then a spurious done tick
    offer(3, 8'h99, 1'b1);
    #1;
    check("rw_ready", req_ready, 4'b1000);
    step();
    req_valid[3] = 1'b0;
    check("rw_start", tx_start, 1);
    step();
    check("rw_wait_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check_reset_values("rw_after");
    step();
    check("rw_no_start", tx_start, 0);
    offer(0, 8'h5A, 1'b1);
    offer(2, 8'h6B, 1'b1);
    xfer(0, 8'h5A, 0, 8'h00, 0);
    xfer(2, 8'h6B, 0, 8'h00, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 249) == 0) reset = 1'b1;
      tx_done_tick = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          offer(i, 8'($urandom), $urandom_range(0, 2) == 0);
      end
    end
    req_valid = '0;
    tx_done_tick = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
